// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed multiply/divide engine for the EX stage.
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   start, op_div       issue an op this cycle (0 = multiply, 1 = divide)
//   src_a, src_b        signed operands (multiplicand/dividend, multiplier/divisor)
//   flush               squash of the in-flight op
//   stall               freeze IF/ID/EX while the op is accepted or running
//   done                one-cycle pulse, result valid
//   result, result_hi   product low/high half, or quotient/remainder
//   div_zero            divide by zero occurred (valid with done)
// Optional build macro MULDIV_EARLY_EXIT_EN: trivial ops (zero multiply operand,
// divide with |a| < |b|) retire one edge after start.
module muldiv_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic op_q, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b, abs_a, abs_b;
    logic [2*WIDTH-1:0] acc, mul_nxt, div_nxt, prod;
    logic [WIDTH:0] add, rem_sh, trial;
    logic accept, div0, early;

    assign abs_a  = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b  = src_b[WIDTH-1] ? -src_b : src_b;
    assign accept = start && !flush;
    assign div0   = op_div && src_b == '0;
`ifdef MULDIV_EARLY_EXIT_EN
    assign early = op_div ? (src_b != '0 && abs_a < abs_b) : (src_a == '0 || src_b == '0);
`else
    assign early = 1'b0;
`endif

    // Multiply: acc = {high, multiplier}; add |a| into the high half on the
    // multiplier LSB, then shift the whole product right (carry enters the top).
    assign add     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_nxt = {add, acc[WIDTH-1:1]};
    // Divide: acc = {rem, quot}; shift left, keep the trial difference unless it borrows.
    assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign trial   = rem_sh - {1'b0, mag_b};
    assign div_nxt = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    // Low half of the negated 2*WIDTH value equals the negated quotient, so
    // prod[WIDTH-1:0] serves as both product-low and signed quotient.
    assign prod    = (sa ^ sb) ? -acc : acc;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept)
                    state_nxt = (div0 || early) ? DONE : RUN;
            end
            RUN: begin
                stall     = !flush;
                state_nxt = flush ? IDLE : (cnt == LAST ? FIX : RUN);
            end
            FIX: begin
                stall     = !flush;
                state_nxt = flush ? IDLE : DONE;
            end
            default: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt       <= '0;
            op_q      <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            acc       <= '0;
            result    <= '0;
            result_hi <= '0;
            div_zero  <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                op_q  <= op_div;
                sa    <= src_a[WIDTH-1];
                sb    <= src_b[WIDTH-1];
                mag_a <= abs_a;
                mag_b <= abs_b;
                acc   <= {{WIDTH{1'b0}}, op_div ? abs_a : abs_b};
                cnt   <= '0;
                if (div0) begin
                    result    <= '1;
                    result_hi <= src_a;
                    div_zero  <= 1'b1;
                end else if (early) begin
                    result    <= '0;
                    result_hi <= op_div ? src_a : '0;
                    div_zero  <= 1'b0;
                end
            end
            if (state == RUN) begin
                acc <= op_q ? div_nxt : mul_nxt;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX && !flush) begin
                result    <= prod[WIDTH-1:0];
                result_hi <= op_q ? (sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                                  : prod[2*WIDTH-1:WIDTH];
                div_zero  <= 1'b0;
            end
        end
endmodule
